// File: rtl/level_meter.sv
// level_meter: rectify and average audio samples per window, drive a log-scale LED bar
// with a decaying peak-hold dot, a per-window done strobe and a sticky overrun flag.
module level_meter #(
    parameter int DATA_W   = 8,
    parameter int WIN_LOG2 = 8,
    parameter int HOLD_WIN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] audio_data,
    output logic [DATA_W-1:0] LED,
    output logic [DATA_W-1:0] peak_led,
    output logic [DATA_W-1:0] level,
    output logic              done,
    output logic              overrun
);
    localparam int NW = $clog2(DATA_W + 1);
    localparam int SW = DATA_W + WIN_LOG2;
    localparam int HW = $clog2(HOLD_WIN + 2);

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_AVG, S_ENCODE, S_PEAK} state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   mag_q, level_q, led_q, peak_led_q;
    logic [SW-1:0]       sum_q;
    logic [WIN_LOG2-1:0] count_q;
    logic [NW-1:0]       peak_cnt_q, peak_cnt_d, n_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic                done_q, overrun_q, grow;

    always_comb begin
        n_d = '0;
        for (int i = 0; i < DATA_W; i++)
            if (level_q[i]) n_d = NW'(i + 1);
        grow = n_d >= peak_cnt_q;
        peak_cnt_d = grow ? n_d : (hold_q != '0 ? peak_cnt_q : peak_cnt_q - 1'b1);
        hold_d = grow ? HW'(HOLD_WIN) : (hold_q != '0 ? hold_q - 1'b1 : hold_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mag_q      <= '0;
            sum_q      <= '0;
            count_q    <= '0;
            level_q    <= '0;
            led_q      <= '0;
            peak_led_q <= '0;
            peak_cnt_q <= '0;
            hold_q     <= '0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start && state_q != S_IDLE) overrun_q <= 1'b1;
            case (state_q)
                S_IDLE: if (start) begin
                    mag_q   <= audio_data[DATA_W-1] ? -audio_data : audio_data;
                    state_q <= S_ACCUM;
                end
                S_ACCUM: begin
                    sum_q   <= sum_q + SW'(mag_q);
                    count_q <= count_q + 1'b1;
                    state_q <= &count_q ? S_AVG : S_IDLE;
                end
                S_AVG: begin
                    level_q <= sum_q[WIN_LOG2 +: DATA_W];
                    state_q <= S_ENCODE;
                end
                S_ENCODE: begin
                    led_q   <= ~({DATA_W{1'b1}} >> n_d);
                    state_q <= S_PEAK;
                end
                S_PEAK: begin
                    peak_cnt_q <= peak_cnt_d;
                    hold_q     <= hold_d;
                    // dot sits peak_cnt positions below the MSB end of the bar
                    peak_led_q <= peak_cnt_d == '0 ? '0 : DATA_W'(1) << (NW'(DATA_W) - peak_cnt_d);
                    done_q     <= 1'b1;
                    sum_q      <= '0;
                    count_q    <= '0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign LED      = led_q;
    assign peak_led = peak_led_q;
    assign level    = level_q;
    assign done     = done_q;
    assign overrun  = overrun_q;
endmodule

// File: tb/tb_level_meter.sv
// tb_level_meter: directed windows against hand-computed levels, bars, peak dots and flags.
module tb_level_meter;
    logic       clk = 1'b0, reset, start;
    logic [7:0] audio_data;
    logic [7:0] led, peak_led, level, led_h, peak_led_h, level_h;
    logic       done, overrun, done_h, overrun_h;
    int checks = 0, failures = 0, done_cnt = 0, d0;
    int peak_idx [2:10] = '{1, 1, 2, 3, 4, 5, 6, 7, 7};

    level_meter u_dut (
        .clk(clk), .reset(reset), .start(start), .audio_data(audio_data),
        .LED(led), .peak_led(peak_led), .level(level), .done(done), .overrun(overrun)
    );

    level_meter #(.HOLD_WIN(2)) u_hold (
        .clk(clk), .reset(reset), .start(start), .audio_data(audio_data),
        .LED(led_h), .peak_led(peak_led_h), .level(level_h), .done(done_h), .overrun(overrun_h)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] s);
        @(negedge clk);
        start = 1'b1;
        audio_data = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_n(input logic [7:0] s, input int n);
        repeat (n) send(s);
    endtask

    task automatic finish_win(input string tag);
        int lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (done) lat = k;
        end
        check({tag, "_done_lat"}, lat, 4);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        audio_data = '0;
        repeat (3) @(negedge clk);
        check("rst_led", led, 0);
        check("rst_peak", peak_led, 0);
        check("rst_level", level, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b0;

        send_n(8'h10, 256);
        finish_win("def");
        check("def_level", level, 8'h10);
        check("def_led", led, 8'b1111_1000);
        check("def_peak", peak_led, 8'b0000_1000);
        check("def_done_cnt", done_cnt, 1);

        do_reset();
        send_n(8'hF0, 256);
        finish_win("neg1");
        check("neg1_level", level, 8'h10);
        check("neg1_led", led, 8'b1111_1000);
        send_n(8'h80, 256);
        finish_win("neg2");
        check("neg2_level", level, 8'h80);
        check("neg2_led", led, 8'hFF);

        do_reset();
        send_n(8'h7F, 128);
        send_n(8'h00, 128);
        finish_win("mix");
        check("mix_level", level, 8'h3F);
        check("mix_led", led, 8'b1111_1100);

        do_reset();
        send_n(8'h40, 256);
        finish_win("pk1");
        check("pk1_dot", peak_led_h, 8'b0000_0010);
        check("pk1_led", led_h, 8'b1111_1110);
        for (int w = 2; w <= 10; w++) begin
            send_n(8'h01, 256);
            finish_win("pk");
            check($sformatf("pk%0d_dot", w), peak_led_h, 32'd1 << peak_idx[w]);
            check($sformatf("pk%0d_led", w), led_h, 8'b1000_0000);
        end

        do_reset();
        check("ovr_clear0", overrun, 0);
        @(negedge clk);
        start = 1'b1;
        audio_data = 8'h10;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        check("ovr_set", overrun, 1);
        d0 = done_cnt;
        send_n(8'h10, 254);
        @(negedge clk);
        check("ovr_no_early_done", done_cnt, d0);
        send(8'h10);
        finish_win("ovr");
        check("ovr_level", level, 8'h10);
        check("ovr_sticky", overrun, 1);
        do_reset();
        check("ovr_reset_clears", overrun, 0);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        audio_data = 8'h80;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_start_overrun", overrun, 0);
        check("rst_start_level", level, 0);

        do_reset();
        send_n(8'h7F, 100);
        do_reset();
        d0 = done_cnt;
        send_n(8'h02, 255);
        @(negedge clk);
        check("mid_no_done", done_cnt, d0);
        send(8'h02);
        finish_win("mid");
        check("mid_level", level, 8'h02);
        check("mid_led", led, 8'b1100_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/level_meter.md
# level_meter

Parametrised audio level meter. It rectifies signed audio samples and averages them over a window of 2^WIN_LOG2 samples. The average drives a log-scale LED bar, and a peak-hold dot decays after a programmable number of windows. It sits after the audio sample source and drives the board LEDs. It also adds two things to the basic averaging meter: a sticky overrun flag and a per-window done strobe.

## Interface
- DATA_W, 8, sample width and LED count (≥2)
- WIN_LOG2, 8, log2 of samples per window (≥1)
- HOLD_WIN, 4, windows the peak dot holds before decaying (≥0)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; priority over all other inputs
- start  in  1  sample strobe; audio_data valid in the same cycle
- audio_data  in  DATA_W  two's-complement sample
- LED  out  DATA_W  thermometer bar of the window average
- peak_led  out  DATA_W  one-hot peak-hold dot, or all zero
- level  out  DATA_W  unsigned window average magnitude
- done  out  1  one-cycle pulse when LED, level and peak_led have all been updated
- overrun  out  1  sticky: a start arrived while the block was busy

## Operation
- State machine: S_IDLE, S_ACCUM, S_AVG, S_ENCODE, S_PEAK.
- S_IDLE with start=1:
  - mag <= |audio_data|, held as DATA_W unsigned bits.
  - Most-negative input gives exactly 2^(DATA_W-1); no saturation.
  - Next state S_ACCUM.
- S_ACCUM:
  - sum <= sum + mag; count <= count + 1.
  - sum is DATA_W+WIN_LOG2 bits; count is WIN_LOG2 bits.
  - If count == 2^WIN_LOG2-1 (last sample of the window), go to S_AVG; otherwise go to S_IDLE.
  - Each window contains exactly 2^WIN_LOG2 accepted samples.
- S_AVG: level <= sum[WIN_LOG2 +: DATA_W] (truncating divide).
- S_ENCODE:
  - n = index of highest set bit of level, plus 1; n=0 if level=0.
  - LED[DATA_W-1 -: n] = 1, all other LED bits 0, so the bar fills from the MSB.
- S_PEAK:
  - If n ≥ peak_cnt: peak_cnt <= n, hold <= HOLD_WIN.
  - Else if hold ≠ 0: hold <= hold-1.
  - Else: peak_cnt <= peak_cnt-1 (decays one LED per window).
  - peak_led = one-hot at bit DATA_W-peak_cnt, or 0 when peak_cnt = 0.
  - Also in this state: done <= 1, sum <= 0, count <= 0, next state S_IDLE.
- start is accepted only in S_IDLE.
  - A start seen in any other state is dropped and sets overrun <= 1.
  - Only reset clears overrun.
- Reset:
  - Outputs: LED, peak_led, level = 0; done = 0; overrun = 0.
  - Internal: state = S_IDLE; sum, count, mag, peak_cnt, hold = 0.
  - A reset mid-window discards the partial sum; the next window starts from sample 0.

## Timing
- Let E0 be the edge at which start is sampled in S_IDLE.
  - Non-final sample: accumulated at E1, back in S_IDLE after E1. Samples may therefore be 2 cycles apart.
  - Final sample: level updates at E2, LED at E3, peak_led and done at E4. done stays high for exactly one cycle after E4.
  - The next start is accepted at E5 or later. A start at E1–E4 sets overrun.
- All outputs are registered and hold their values between windows.
- reset together with start: reset wins, the sample is not accepted, and overrun stays 0.

## Test plan
- Defaults: reset, then 256 samples of 0x10, 2 cycles apart.
  - level=0x10, LED=8'b1111_1000, peak_led=8'b0000_1000.
  - done pulses once, 4 edges after the last start.
- Negative inputs, two windows:
  - 256 × 0xF0 -> level=0x10, LED=8'b1111_1000.
  - Then 256 × 0x80 -> level=0x80, LED=8'hFF.
- Mixed window: 128 × 0x7F then 128 × 0x00.
  - sum=16256 -> level=0x3F, LED=8'b1111_1100.
- Peak hold, HOLD_WIN=2: one window of 0x40 (n=7), then windows of 0x01 (n=1).
  - peak_led index after windows 1..4 = 1,1,1,2.
  - It then advances one position per window to index 7 and stays there.
  - LED=8'b1000_0000 from window 2 onward.
- Overrun: start on two consecutive cycles.
  - The second start is dropped, overrun=1, and the window completes only after one extra accepted sample.
  - A subsequent reset clears overrun.
- Reset mid-window: 100 × 0x7F, reset, then 256 × 0x02.
  - level=0x02, LED=8'b1100_0000, no done pulse before the new window completes.
